// File: rtl/dram_arbiter.sv
// Two-port DRAM arbiter: instruction-fetch (read-only) and data ports share one cs/we/ack DRAM.
// Define DRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with the D port winning ties.
module dram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic              i_err_o,
  output logic [DATA_W-1:0] i_data_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WDOG_W-1:0] wdog;
  logic              owner_d;
  logic              lat_we;
  logic              any_req;
  logic              grant_d;
  logic              got_ack;
  logic              timed_out;
  logic              cs_nxt;
  logic              we_nxt;
  logic              i_ack_nxt;
  logic              d_ack_nxt;

`ifdef DRAM_ARB_RR_EN
  // last_d remembers the previous winner; on a tie the other port gets the grant.
  logic last_d;
  assign grant_d = d_req_i & (~i_req_i | ~last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (cs_nxt) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = d_req_i;
`endif

  assign any_req   = i_req_i | d_req_i;
  assign got_ack   = (state == S_WAIT) & mem_ack_i;
  assign timed_out = (state == S_WAIT) & ~mem_ack_i & (wdog == WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (got_ack || timed_out) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered strobes, so they line up with the state they belong to.
  always_comb begin
    cs_nxt    = (state == S_IDLE) && any_req;
    we_nxt    = cs_nxt && grant_d && d_we_i;
    i_ack_nxt = (got_ack || timed_out) && !owner_d;
    d_ack_nxt = (got_ack || timed_out) && owner_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cs_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      owner_d    <= 1'b0;
      lat_we     <= 1'b0;
      wdog       <= '0;
      i_ack_o    <= 1'b0;
      i_err_o    <= 1'b0;
      i_data_o   <= '0;
      d_ack_o    <= 1'b0;
      d_err_o    <= 1'b0;
      d_data_o   <= '0;
    end else begin
      mem_cs_o <= cs_nxt;
      mem_we_o <= we_nxt;
      i_ack_o  <= i_ack_nxt;
      i_err_o  <= i_ack_nxt && timed_out;
      d_ack_o  <= d_ack_nxt;
      d_err_o  <= d_ack_nxt && timed_out;

      // Request fields are frozen here; later input changes cannot disturb the access.
      if (cs_nxt) begin
        owner_d    <= grant_d;
        lat_we     <= grant_d & d_we_i;
        mem_addr_o <= grant_d ? d_addr_i : i_addr_i;
        mem_data_o <= grant_d ? d_data_i : '0;
      end

      if (state == S_ISSUE) begin
        wdog <= '0;
      end else if (state == S_WAIT && !mem_ack_i) begin
        wdog <= wdog + WDOG_W'(1);
      end

      // An aborted access clears the owner's data; a completed write leaves it untouched.
      if (i_ack_nxt) begin
        if (timed_out) begin
          i_data_o <= '0;
        end else if (!lat_we) begin
          i_data_o <= mem_data_i;
        end
      end

      if (d_ack_nxt) begin
        if (timed_out) begin
          d_data_o <= '0;
        end else if (!lat_we) begin
          d_data_o <= mem_data_i;
        end
      end
    end
  end

endmodule
